// File: rtl/mips_cpu_bus_pkg.sv
// mips_cpu_bus_pkg: shared state and port-select types for the CPU bus arbiter
package mips_cpu_bus_pkg;
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;
endpackage

// File: rtl/mips_cpu_rr_arbiter.sv
// mips_cpu_rr_arbiter: picks instruction or data port from two requests and the last grant
module mips_cpu_rr_arbiter
    import mips_cpu_bus_pkg::*;
#(
    parameter int DATA_PRIORITY = 0
) (
    input  logic  i_req_i,
    input  logic  i_req_d,
    input  port_t i_last_grant,
    output port_t o_grant
);
    logic w_pick_d;
    // Data wins when alone, under fixed priority, or when instruction was served last
    always_comb begin
        w_pick_d = i_req_d && (!i_req_i || (DATA_PRIORITY != 0) || (i_last_grant == PORT_I));
        o_grant  = w_pick_d ? PORT_D : PORT_I;
    end
endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter: shares one memory bus between instruction fetch and data ports
module mips_cpu_bus_arbiter
    import mips_cpu_bus_pkg::*;
#(
    parameter int DATA_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [3:0]  d_byteenable,
    input  logic [31:0] d_address,
    input  logic [31:0] d_writedata,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,
    output logic        m_read,
    output logic        m_write,
    output logic [3:0]  m_byteenable,
    output logic [31:0] m_address,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata
);
    state_t r_state, w_next_state;
    port_t  r_last, w_next_last, w_grant;
    logic   r_chained, w_next_chained;
    logic   w_i_req, w_d_req;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    mips_cpu_rr_arbiter #(.DATA_PRIORITY(DATA_PRIORITY)) u_arb (
        .i_req_i      (w_i_req),
        .i_req_d      (w_d_req),
        .i_last_grant (r_last),
        .o_grant      (w_grant)
    );

    // State, last-served port and handoff flag; reset abandons any transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_last    <= PORT_I;
            r_chained <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_last    <= w_next_last;
            r_chained <= w_next_chained;
        end
    end

    // Next state: each port is served at most once between visits to IDLE
    always_comb begin
        w_next_state   = r_state;
        w_next_last    = r_last;
        w_next_chained = r_chained;
        unique case (r_state)
            IDLE: begin
                w_next_chained = 1'b0;
                if (w_i_req || w_d_req)
                    w_next_state = (w_grant == PORT_D) ? GNT_D : GNT_I;
            end
            GNT_I: begin
                if (!w_i_req) begin
                    w_next_state = IDLE;
                end else if (!m_waitrequest) begin
                    w_next_last    = PORT_I;
                    w_next_chained = 1'b1;
                    w_next_state   = (w_d_req && !r_chained) ? GNT_D : IDLE;
                end
            end
            GNT_D: begin
                if (!w_d_req) begin
                    w_next_state = IDLE;
                end else if (!m_waitrequest) begin
                    w_next_last    = PORT_D;
                    w_next_chained = 1'b1;
                    w_next_state   = (w_i_req && !r_chained) ? GNT_I : IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Bus steering: granted port passes through, the other stalls; a write overrides a read
    always_comb begin
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_byteenable  = 4'b0000;
        m_address     = 32'h0;
        m_writedata   = 32'h0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        i_readdata    = m_readdata;
        d_readdata    = m_readdata;
        if (r_state == GNT_I) begin
            m_read        = i_read;
            m_address     = i_address;
            m_byteenable  = 4'b1111;
            i_waitrequest = m_waitrequest;
        end else if (r_state == GNT_D) begin
            m_read        = d_read & ~d_write;
            m_write       = d_write;
            m_byteenable  = d_byteenable;
            m_address     = d_address;
            m_writedata   = d_writedata;
            d_waitrequest = m_waitrequest;
        end
    end
endmodule
